// File: rtl/static_alu_sched_pkg.sv
// Shared definitions for the static ALU issue scheduler.
//   - op encodings for the two-bit ALU operation field
//   - op_lat(): cycles from issue to ALU result for a given op
//   - req_t / rsp_t: unpacked views of one request and one response
package static_alu_sched_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        exception;
    logic        overflow;
    logic        underflow;
  } rsp_t;

  // Add/sub use the add pipe; mul and the reserved op use the mul pipe.
  function automatic int unsigned op_lat(input logic [1:0] op,
                                         input int unsigned add_lat,
                                         input int unsigned mul_lat);
    if (op == OP_ADD || op == OP_SUB) begin
      op_lat = add_lat;
    end else begin
      op_lat = mul_lat;
    end
  endfunction

endpackage

// File: rtl/static_alu_rr_arb.sv
// Masked round-robin arbiter.
//   req      in   N      request vector (already filtered for eligibility)
//   ptr      in   ID_W   highest-priority requester index
//   grant    out  N      one-hot grant, zero when no request
//   grant_id out  ID_W   index of the granted requester
//   grant_valid out 1    some request was granted
// Purely combinational; the pointer register lives in the caller.
module static_alu_rr_arb #(
  parameter  int N    = 2,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_valid
);

  logic [N-1:0] mask_s;
  logic [N-1:0] pick_s;

  // Requests at or above the pointer win; wrap to the full vector when none are there.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (i >= int'(ptr)) ? 1'b1 : 1'b0;
    end
    pick_s      = ((req & mask_s) != '0) ? (req & mask_s) : req;
    // Isolate the lowest set bit.
    grant       = pick_s & (~pick_s + {{(N-1){1'b0}}, 1'b1});
    grant_valid = |req;
  end

  // Encode the one-hot grant into an index.
  always_comb begin
    grant_id = '0;
    for (int i = 0; i < N; i++) begin
      grant_id = grant_id | (grant[i] ? ID_W'(i) : '0);
    end
  end

endmodule

// File: rtl/static_alu_issue_sched.sv
// Issue scheduler sharing one fixed-latency ALU among NUM_REQ requesters.
// Round-robin issue of at most one op per cycle; a writeback reservation
// vector guarantees no two results appear in the same cycle, and a parallel
// tag vector routes each result back to its requester.
//   clk, reset                         clock, async active-high reset
//   req_valid/req_ready  [NUM_REQ]     per-requester handshake (ready one-hot or zero)
//   req_a/req_b [NUM_REQ*32], req_op [NUM_REQ*2]  packed request fields
//   alu_operand_a/b, alu_operation     combinational drive of the granted op
//   alu_result + flags                 ALU outputs
//   rsp_valid/rsp_id/rsp_result + flags  routed result (no backpressure)
//   sched_idle                         nothing in flight
// Optional macro STATIC_ALU_SCHED_PERF_EN adds perf_issue_cnt and
// perf_conflict_cnt (saturating 32-bit counters).
module static_alu_issue_sched
  import static_alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int ADD_LAT = 3,
  parameter  int MUL_LAT = 4,
  localparam int MAX_LAT = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  input  logic [NUM_REQ*2-1:0] req_op,
  output logic [31:0]          alu_operand_a,
  output logic [31:0]          alu_operand_b,
  output logic [1:0]           alu_operation,
  input  logic [31:0]          alu_result,
  input  logic                 alu_exception,
  input  logic                 alu_overflow,
  input  logic                 alu_underflow,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_result,
  output logic                 rsp_exception,
  output logic                 rsp_overflow,
  output logic                 rsp_underflow,
`ifdef STATIC_ALU_SCHED_PERF_EN
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_conflict_cnt,
`endif
  output logic                 sched_idle
);

  localparam int LW = $clog2(MAX_LAT + 1);

  logic [MAX_LAT:0]           res_r;
  logic [MAX_LAT:0][ID_W-1:0] tag_r;
  logic [ID_W-1:0]            ptr_r;

  req_t             req_s [NUM_REQ];
  logic [LW-1:0]    lat_s [NUM_REQ];
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] blocked_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]  grant_id_s;
  logic             grant_valid_s;
  logic [LW-1:0]    issue_slot_s;
  rsp_t             rsp_s;

  // Unpack requests; a requester is blocked when its completion slot is taken.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_s[i].a   = req_a[32*i +: 32];
      req_s[i].b   = req_b[32*i +: 32];
      req_s[i].op  = req_op[2*i +: 2];
      lat_s[i]     = LW'(op_lat(req_op[2*i +: 2], ADD_LAT, MUL_LAT));
      blocked_s[i] = req_valid[i] & res_r[lat_s[i]];
      elig_s[i]    = req_valid[i] & ~res_r[lat_s[i]] & ~reset;
    end
  end

  static_alu_rr_arb #(.N(NUM_REQ)) u_arb (
    .req         (elig_s),
    .ptr         (ptr_r),
    .grant       (grant_s),
    .grant_id    (grant_id_s),
    .grant_valid (grant_valid_s)
  );

  // Handshake and ALU drive; an idle cycle presents add of zeros.
  always_comb begin
    req_ready    = grant_s;
    issue_slot_s = lat_s[grant_id_s] - LW'(1);
    if (grant_valid_s) begin
      alu_operand_a = req_s[grant_id_s].a;
      alu_operand_b = req_s[grant_id_s].b;
      alu_operation = req_s[grant_id_s].op;
    end else begin
      alu_operand_a = 32'd0;
      alu_operand_b = 32'd0;
      alu_operation = OP_ADD;
    end
  end

  // Reservation/tag shift register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_r <= '0;
      tag_r <= '0;
      ptr_r <= '0;
    end else begin
      for (int k = 0; k < MAX_LAT; k++) begin
        res_r[k] <= res_r[k+1];
        tag_r[k] <= tag_r[k+1];
      end
      res_r[MAX_LAT] <= 1'b0;
      tag_r[MAX_LAT] <= '0;
      // Slot L-1 after the shift is the cycle L from now.
      if (grant_valid_s) begin
        res_r[issue_slot_s] <= 1'b1;
        tag_r[issue_slot_s] <= grant_id_s;
        ptr_r <= (grant_id_s == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_s + ID_W'(1);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // The ALU output is meaningful only when a reservation matures this cycle.
  always_comb begin
    if (res_r[0]) begin
      rsp_s = '{result: alu_result, exception: alu_exception,
                overflow: alu_overflow, underflow: alu_underflow};
      rsp_id = tag_r[0];
    end else begin
      rsp_s  = '0;
      rsp_id = '0;
    end
    rsp_valid     = res_r[0];
    rsp_result    = rsp_s.result;
    rsp_exception = rsp_s.exception;
    rsp_overflow  = rsp_s.overflow;
    rsp_underflow = rsp_s.underflow;
    sched_idle    = ~|res_r;
  end

`ifdef STATIC_ALU_SCHED_PERF_EN
  // Saturating issue and reservation-conflict counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issue_cnt    <= 32'd0;
      perf_conflict_cnt <= 32'd0;
    end else begin
      if (grant_valid_s && perf_issue_cnt != 32'hFFFF_FFFF) begin
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
      end else begin
        perf_issue_cnt <= perf_issue_cnt;
      end
      if ((|blocked_s) && perf_conflict_cnt != 32'hFFFF_FFFF) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end else begin
        perf_conflict_cnt <= perf_conflict_cnt;
      end
    end
  end
`endif

endmodule
